// File: rtl/nrf_spi_pkg.sv
// Shared definitions for the multi-channel nRF24L01 SPI master.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package nrf_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // nRF24L01 command opcodes
    localparam logic [7:0] R_REGISTER   = 8'h00;
    localparam logic [7:0] W_REGISTER   = 8'h20;
    localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] FLUSH_TX     = 8'hE1;
    localparam logic [7:0] NOP          = 8'hFF;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/nrf_spi_half_tick.sv
// SCK half-period timebase: pulses o_tick on every CLK_DIV-th cycle while enabled.
// Latency: first tick CLK_DIV cycles after i_clr drops; counter restarts after every tick.
// Backpressure: none; i_clr holds the counter at zero and suppresses the tick.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_clr synchronous clear,
//        o_tick one-cycle half-period strobe.
module nrf_spi_half_tick
    import nrf_spi_pkg::*;
#(
    parameter int CLK_DIV = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = clog2_min1(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_MAX) && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nrf_spi_master_mc.sv
// Multi-channel SPI master (mode 0, MSB first) for nRF24L01 radios: cmd + 0..MAX_BYTES payload.
// Latency: done pulses 2*CLK_DIV + 16*CLK_DIV*(tx_len+1) + CSN_GAP + 1 cycles after start is taken.
// Backpressure: start only sampled while busy=0; bad requests pulse err; abort drops to the CSN gap.
// Ports: clk_in/key0_rst clock and async active-low reset; start/ch_sel/cmd/tx_len/tx_data request;
//        abort cancel; ce_in/ce radio CE lines; busy/done/err/status/rx_data result;
//        csn/sck/mosi/miso per-radio SPI pins.
module nrf_spi_master_mc
    import nrf_spi_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 3,
    parameter int CSN_GAP   = 4,
    // derived widths, not meant to be overridden
    parameter int CH_W      = clog2_min1(N_CH),
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_in,
    input  logic                   key0_rst,
    input  logic                   start,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic [7:0]             cmd,
    input  logic [LEN_W-1:0]       tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    input  logic                   abort,
    input  logic [N_CH-1:0]        ce_in,
    input  logic [N_CH-1:0]        miso,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [7:0]             status,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic [N_CH-1:0]        csn,
    output logic [N_CH-1:0]        sck,
    output logic [N_CH-1:0]        mosi,
    output logic [N_CH-1:0]        ce
);

    localparam int TXW   = 8 * (MAX_BYTES + 1);
    localparam int BC_W  = $clog2(8 * (MAX_BYTES + 1));
    localparam int GAP_W = clog2_min1(CSN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_END = GAP_W'(CSN_GAP);

    spi_state_t             r_state;
    spi_state_t             w_state_nxt;
    logic [CH_W-1:0]        r_ch;
    logic [LEN_W-1:0]       r_len;
    logic [TXW-1:0]         r_tx_sr;
    logic [7:0]             r_rx_byte;
    logic [7:0]             r_stat_tmp;
    logic [8*MAX_BYTES-1:0] r_rx_tmp;
    logic [BC_W-1:0]        r_bit_cnt;
    logic                   r_phase;      // 0: sck low half, 1: sck high half
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_aborted;
    logic                   r_done;
    logic                   r_err;
    logic [7:0]             r_status;
    logic [8*MAX_BYTES-1:0] r_rx_data;
    logic [N_CH-1:0]        r_ce;

    logic                   w_tick;
    logic                   w_tick_clr;
    logic                   w_start_ok;
    logic                   w_in_xfer;
    logic                   w_is_last;
    logic                   w_gap_end;
    logic                   w_miso;
    logic [7:0]             w_rx_byte_nxt;
    logic [BC_W-1:0]        w_last_bit;
    logic [BC_W-4:0]        w_byte_idx;
    logic [TXW-1:0]         w_tx_load;
    logic                   w_csn_low;
    logic                   w_sck_hi;
    logic                   w_mosi_bit;

    // Zero-extend before comparing so the check stays meaningful for any parameter set.
    assign w_start_ok = ({1'b0, tx_len} <= (LEN_W + 1)'(MAX_BYTES)) &&
                        ({1'b0, ch_sel} <  (CH_W + 1)'(N_CH));
    assign w_in_xfer  = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
    assign w_last_bit = BC_W'({r_len, 3'b111});
    assign w_is_last  = (r_bit_cnt == w_last_bit);
    assign w_byte_idx = r_bit_cnt[BC_W-1:3];
    assign w_gap_end  = (r_state == ST_GAP) && (r_gap_cnt == GAP_END);
    assign w_miso     = miso[r_ch];
    assign w_rx_byte_nxt = {r_rx_byte[6:0], w_miso};
    assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_GAP) || abort;

    // Outgoing stream: command in the top byte, then payload byte 0, 1, ...
    always_comb begin
        w_tx_load = '0;
        w_tx_load[TXW-1 -: 8] = cmd;
        for (int k = 0; k < MAX_BYTES; k++) begin
            w_tx_load[8*(MAX_BYTES-1-k) +: 8] = tx_data[8*k +: 8];
        end
    end

    nrf_spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .i_clk   (clk_in),
        .i_rst_n (key0_rst),
        .i_clr   (w_tick_clr),
        .o_tick  (w_tick)
    );

    // FSM: state register
    always_ff @(posedge clk_in or negedge key0_rst) begin
        if (!key0_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start && w_start_ok) w_state_nxt = ST_SETUP;
            ST_SETUP: if (abort) w_state_nxt = ST_GAP;
                      else if (w_tick) w_state_nxt = ST_SHIFT;
            // terminal bit count forces HOLD on its falling half, never wraps
            ST_SHIFT: if (abort) w_state_nxt = ST_GAP;
                      else if (w_tick && r_phase && w_is_last) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (abort) w_state_nxt = ST_GAP;
                      else if (w_tick) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_gap_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: pin outputs, demuxed onto the selected radio only
    always_comb begin
        w_csn_low  = w_in_xfer;
        w_sck_hi   = (r_state == ST_SHIFT) && r_phase;
        w_mosi_bit = ((r_state == ST_SETUP) || (r_state == ST_SHIFT)) && r_tx_sr[TXW-1];
        csn  = '1;
        sck  = '0;
        mosi = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_ch == CH_W'(i)) begin
                csn[i]  = !w_csn_low;
                sck[i]  = w_sck_hi;
                mosi[i] = w_mosi_bit;
            end
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign status  = r_status;
    assign rx_data = r_rx_data;
    assign ce      = r_ce;

    // Datapath: request capture, shifting, result commit
    always_ff @(posedge clk_in or negedge key0_rst) begin
        if (!key0_rst) begin
            r_ch       <= '0;
            r_len      <= '0;
            r_tx_sr    <= '0;
            r_rx_byte  <= '0;
            r_stat_tmp <= '0;
            r_rx_tmp   <= '0;
            r_bit_cnt  <= '0;
            r_phase    <= 1'b0;
            r_gap_cnt  <= '0;
            r_aborted  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_status   <= '0;
            r_rx_data  <= '0;
            r_ce       <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_ce   <= ce_in;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;

            if (abort && w_in_xfer) begin
                r_aborted <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && w_start_ok) begin
                        r_ch       <= ch_sel;
                        r_len      <= tx_len;
                        r_tx_sr    <= w_tx_load;
                        r_stat_tmp <= '0;
                        r_rx_tmp   <= '0;
                        r_bit_cnt  <= '0;
                        r_phase    <= 1'b0;
                        r_aborted  <= 1'b0;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick && !abort) begin
                        if (!r_phase) begin
                            // sck rising: sample MISO, commit each completed byte
                            r_phase   <= 1'b1;
                            r_rx_byte <= w_rx_byte_nxt;
                            if (r_bit_cnt[2:0] == 3'b111) begin
                                if (w_byte_idx == '0) begin
                                    r_stat_tmp <= w_rx_byte_nxt;
                                end
                                for (int k = 0; k < MAX_BYTES; k++) begin
                                    if (w_byte_idx == (BC_W - 3)'(k + 1)) begin
                                        r_rx_tmp[8*k +: 8] <= w_rx_byte_nxt;
                                    end
                                end
                            end
                        end else begin
                            // sck falling: present the next MOSI bit
                            r_phase <= 1'b0;
                            if (!w_is_last) begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_tx_sr   <= {r_tx_sr[TXW-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_end && !r_aborted) begin
                        r_done    <= 1'b1;
                        r_status  <= r_stat_tmp;
                        r_rx_data <= r_rx_tmp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
